// File: rtl/muldiv_unit_if.sv
// Decode-side handshake for the iterative multiply/divide unit: request,
// operands and flush from the pipeline; completion pulse, result and busy back.
interface muldiv_unit_if #(parameter int XLEN = 32);
  logic            is_m;
  logic            is_d;
  logic [2:0]      funct3;
  logic [XLEN-1:0] src_a;
  logic [XLEN-1:0] src_b;
  logic            kill;
  logic            fin;
  logic [XLEN-1:0] result;
  logic            busy;

  modport master (output is_m, is_d, funct3, src_a, src_b, kill,
                  input  fin, result, busy);
  modport slave  (input  is_m, is_d, funct3, src_a, src_b, kill,
                  output fin, result, busy);
endinterface

// File: rtl/muldiv_unit.sv
// Iterative RV32M-style multiply/divide: shift-add multiplier and restoring
// divider on operand magnitudes, one radix-2 step per clock.
//   state | meaning
//   IDLE  | waiting for is_m/is_d; operands captured on start
//   CALC  | XLEN iteration steps, cnt counts down to 0
//   FIN   | result valid, fin pulses unless killed
module muldiv_unit #(parameter int XLEN = 32) (
  input  logic         clk,
  input  logic         rstn,
  muldiv_unit_if.slave mif
);
  localparam int CW = $clog2(XLEN);

  typedef enum logic [1:0] {IDLE, CALC, FIN} state_t;
  state_t state, state_nx;

  logic [CW-1:0]   cnt;
  logic [XLEN-1:0] acc_hi, acc_lo, opnd, result_q;
  logic [2:0]      op;
  logic            neg_q, neg_r, spec;

  logic            start, is_div_in, a_neg, b_neg, div_zero, div_ovf, spec_in;
  logic [XLEN-1:0] mag_a, mag_b, spec_val;
  logic [XLEN:0]   msum, trial, diff;
  logic            ge;
  logic [2*XLEN-1:0] prod, prod_s;
  logic [XLEN-1:0] quot, rem, final_val;

  always_comb begin
    start     = (state == IDLE) && (mif.is_m || mif.is_d) && !mif.kill;
    is_div_in = mif.funct3[2];
    if (is_div_in) begin
      a_neg = !mif.funct3[0] && mif.src_a[XLEN-1];
      b_neg = !mif.funct3[0] && mif.src_b[XLEN-1];
    end else begin
      a_neg = (mif.funct3 == 3'b001 || mif.funct3 == 3'b010) && mif.src_a[XLEN-1];
      b_neg = (mif.funct3 == 3'b001) && mif.src_b[XLEN-1];
    end
    mag_a    = a_neg ? -mif.src_a : mif.src_a;
    mag_b    = b_neg ? -mif.src_b : mif.src_b;
    div_zero = (mif.src_b == '0);
    div_ovf  = !mif.funct3[0] && (mif.src_a == {1'b1, {(XLEN-1){1'b0}}}) &&
               (mif.src_b == '1);
    spec_in  = is_div_in && (div_zero || div_ovf);
    if (div_zero) spec_val = mif.funct3[1] ? mif.src_a : '1;
    else          spec_val = mif.funct3[1] ? '0 : mif.src_a;

    msum  = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opnd} : '0);
    trial = {acc_hi, acc_lo[XLEN-1]};
    ge    = (trial >= {1'b0, opnd});
    diff  = trial - {1'b0, opnd};

    prod   = {acc_hi, acc_lo};
    prod_s = neg_q ? -prod : prod;
    quot   = neg_q ? -acc_lo : acc_lo;
    rem    = neg_r ? -acc_hi : acc_hi;
    if (spec) begin
      final_val = acc_lo;
    end else begin
      case (op)
        3'b000:         final_val = prod_s[XLEN-1:0];
        3'b100, 3'b101: final_val = quot;
        3'b110, 3'b111: final_val = rem;
        default:        final_val = prod_s[2*XLEN-1:XLEN];
      endcase
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (start) state_nx = spec_in ? FIN : CALC;
      CALC:    if (cnt == '0) state_nx = FIN;
      FIN:     state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
    if (mif.kill) state_nx = IDLE;
  end

  always_ff @(posedge clk) begin
    if (!rstn) state <= IDLE;
    else       state <= state_nx;
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      cnt      <= '0;
      acc_hi   <= '0;
      acc_lo   <= '0;
      opnd     <= '0;
      op       <= '0;
      neg_q    <= 1'b0;
      neg_r    <= 1'b0;
      spec     <= 1'b0;
      result_q <= '0;
    end else if (start) begin
      cnt    <= CW'(XLEN-1);
      op     <= mif.funct3;
      neg_q  <= a_neg ^ b_neg;
      neg_r  <= a_neg;
      spec   <= spec_in;
      acc_hi <= '0;
      // Special divides park their answer in acc_lo and bypass CALC.
      acc_lo <= spec_in ? spec_val : (is_div_in ? mag_a : mag_b);
      opnd   <= is_div_in ? mag_b : mag_a;
    end else if (state == CALC) begin
      cnt <= cnt - CW'(1);
      if (op[2]) begin
        acc_hi <= ge ? diff[XLEN-1:0] : trial[XLEN-1:0];
        acc_lo <= {acc_lo[XLEN-2:0], ge};
      end else begin
        {acc_hi, acc_lo} <= {msum, acc_lo[XLEN-1:1]};
      end
    end else if (state == FIN && !mif.kill) begin
      result_q <= final_val;
    end
  end

  assign mif.fin    = (state == FIN) && !mif.kill;
  assign mif.busy   = (state != IDLE);
  assign mif.result = (state == FIN) ? final_val : result_q;
endmodule

// File: tb/tb_muldiv_unit.sv
// Directed bench for muldiv_unit: hand-computed results, latency, busy,
// kill/reset aborts and held-request behaviour.
module tb_muldiv_unit;
  localparam int XLEN = 32;
  localparam int LAT  = XLEN + 1;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  muldiv_unit_if #(.XLEN(XLEN)) mif();
  muldiv_unit #(.XLEN(XLEN)) dut (.clk(clk), .rstn(rstn), .mif(mif));

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Called in cycle T; returns in cycle T+1 with the request still driven.
  task automatic start_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    mif.funct3 = f;
    mif.src_a  = a;
    mif.src_b  = b;
    mif.is_m   = ~f[2];
    mif.is_d   = f[2];
    step();
  endtask

  task automatic watch(input string tag, input int lat, input int win, input int hold_until,
                       input int exp_nfin, input logic [31:0] exp_res);
    int nfin = 0, first = -1, bus_err = 0, consec = 0;
    logic prevfin = 1'b0;
    logic [31:0] res_at = '0;
    for (int k = 1; k <= win; k++) begin
      if (k > hold_until) begin
        mif.is_m = 1'b0;
        mif.is_d = 1'b0;
      end
      if (k <= lat && mif.busy !== 1'b1) bus_err++;
      if (k == lat + 1 && mif.busy !== 1'b0) bus_err++;
      if (mif.fin === 1'b1) begin
        nfin++;
        if (prevfin) consec++;
        if (first < 0) begin
          first  = k;
          res_at = mif.result;
        end
      end
      prevfin = mif.fin;
      step();
    end
    chk({tag, " fin_cycle"}, 64'(first), 64'(lat));
    chk({tag, " fin_count"}, 64'(nfin), 64'(exp_nfin));
    chk({tag, " result"}, 64'(res_at), 64'(exp_res));
    chk({tag, " busy"}, 64'(bus_err), 64'(0));
    chk({tag, " fin_consec"}, 64'(consec), 64'(0));
    chk({tag, " result_held"}, 64'(mif.result), 64'(exp_res));
  endtask

  initial begin
    int nf;
    mif.is_m = 1'b0; mif.is_d = 1'b0; mif.funct3 = '0;
    mif.src_a = '0; mif.src_b = '0; mif.kill = 1'b0;
    repeat (3) step();
    chk("reset fin", 64'(mif.fin), 64'(0));
    chk("reset busy", 64'(mif.busy), 64'(0));
    chk("reset result", 64'(mif.result), 64'(0));
    rstn = 1'b1;
    step();

    start_op(3'b000, 32'd7, 32'hFFFF_FFFD);        watch("mul", LAT, LAT+3, 0, 1, 32'hFFFF_FFEB);
    start_op(3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF); watch("mulhu", LAT, LAT+3, 0, 1, 32'hFFFF_FFFE);
    start_op(3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF); watch("mulh", LAT, LAT+3, 0, 1, 32'h0);
    start_op(3'b010, 32'hFFFF_FFFF, 32'd2);        watch("mulhsu", LAT, LAT+3, 0, 1, 32'hFFFF_FFFF);
    start_op(3'b011, 32'h8000_0000, 32'd4);        watch("mulhu_pow2", LAT, LAT+3, 0, 1, 32'd2);
    start_op(3'b100, 32'hFFFF_FFF9, 32'd2);        watch("div", LAT, LAT+3, 0, 1, 32'hFFFF_FFFD);
    start_op(3'b110, 32'hFFFF_FFF9, 32'd2);        watch("rem", LAT, LAT+3, 0, 1, 32'hFFFF_FFFF);
    start_op(3'b101, 32'd100, 32'd7);              watch("divu", LAT, LAT+3, 0, 1, 32'd14);
    start_op(3'b111, 32'd100, 32'd7);              watch("remu", LAT, LAT+3, 0, 1, 32'd2);
    start_op(3'b100, 32'd7, 32'hFFFF_FFFE);        watch("div_negb", LAT, LAT+3, 0, 1, 32'hFFFF_FFFD);
    start_op(3'b110, 32'd7, 32'hFFFF_FFFE);        watch("rem_negb", LAT, LAT+3, 0, 1, 32'd1);
    start_op(3'b101, 32'h8000_0000, 32'hFFFF_FFFF); watch("divu_big", LAT, LAT+3, 0, 1, 32'd0);

    start_op(3'b100, 32'd5, 32'd0);                watch("div_by0", 1, 4, 0, 1, 32'hFFFF_FFFF);
    start_op(3'b111, 32'd5, 32'd0);                watch("remu_by0", 1, 4, 0, 1, 32'd5);
    start_op(3'b101, 32'd5, 32'd0);                watch("divu_by0", 1, 4, 0, 1, 32'hFFFF_FFFF);
    start_op(3'b110, 32'd5, 32'd0);                watch("rem_by0", 1, 4, 0, 1, 32'd5);
    start_op(3'b100, 32'h8000_0000, 32'hFFFF_FFFF); watch("div_ovf", 1, 4, 0, 1, 32'h8000_0000);
    start_op(3'b110, 32'h8000_0000, 32'hFFFF_FFFF); watch("rem_ovf", 1, 4, 0, 1, 32'd0);

    // Request held through FIN and one more cycle: second start in IDLE right after FIN.
    start_op(3'b000, 32'd3, 32'd4);
    watch("hold", LAT, 2*LAT+3, LAT+1, 2, 32'd12);

    // Kill at T+10, restart at T+11.
    start_op(3'b101, 32'd100, 32'd7);
    mif.is_d = 1'b0;
    nf = 0;
    for (int k = 1; k <= 9; k++) begin
      if (mif.fin === 1'b1) nf++;
      step();
    end
    mif.kill = 1'b1;
    if (mif.fin === 1'b1) nf++;
    step();
    mif.kill = 1'b0;
    chk("kill busy", 64'(mif.busy), 64'(0));
    chk("kill no_fin", 64'(nf), 64'(0));
    start_op(3'b000, 32'd3, 32'd4);
    watch("kill_restart", LAT, LAT+3, 0, 1, 32'd12);

    // Kill has priority over start.
    mif.kill = 1'b1; mif.is_m = 1'b1; mif.funct3 = 3'b000;
    step();
    mif.kill = 1'b0; mif.is_m = 1'b0;
    chk("kill_vs_start busy", 64'(mif.busy), 64'(0));

    // Kill during FIN suppresses fin.
    start_op(3'b000, 32'd2, 32'd2);
    mif.is_m = 1'b0;
    for (int k = 1; k < LAT; k++) step();
    chk("pre_kill in_fin", 64'(mif.fin), 64'(1));
    mif.kill = 1'b1;
    #1;
    chk("kill_fin fin", 64'(mif.fin), 64'(0));
    step();
    mif.kill = 1'b0;
    chk("kill_fin busy", 64'(mif.busy), 64'(0));

    // Reset at T+5 aborts silently; start accepted on first edge with rstn=1.
    start_op(3'b000, 32'd7, 32'hFFFF_FFFD);
    mif.is_m = 1'b0;
    nf = 0;
    for (int k = 1; k <= 4; k++) begin
      if (mif.fin === 1'b1) nf++;
      step();
    end
    rstn = 1'b0;
    step();
    rstn = 1'b1;
    chk("rst busy", 64'(mif.busy), 64'(0));
    chk("rst result", 64'(mif.result), 64'(0));
    chk("rst no_fin", 64'(nf), 64'(0));
    start_op(3'b011, 32'h8000_0000, 32'd4);
    watch("after_rst", LAT, LAT+3, 0, 1, 32'd2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
